// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the writable lookup table: state encoding, table geometry,
// and the column-major image extractor also used by the ROM golden models.
package lut_cfg_pkg;

    localparam int TBL_DEPTH  = 32;
    localparam int TBL_AW     = 5;
    // Widest entry the image extractor handles; narrower tables take the low bits.
    localparam int INIT_MAX_W = 64;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // Bit b of entry a lives at img[TBL_DEPTH*b + a].
    function automatic logic [INIT_MAX_W-1:0] init_entry(
        input logic [TBL_DEPTH*INIT_MAX_W-1:0] img,
        input logic [TBL_AW-1:0]               a
    );
        logic [INIT_MAX_W-1:0] e;
        e = '0;
        for (int b = 0; b < INIT_MAX_W; b++) begin
            e[b] = img[TBL_DEPTH*b + int'(a)];
        end
        return e;
    endfunction

endpackage

// File: rtl/lut_ram_32xw.sv
// 32-entry distributed RAM: one synchronous write port, one asynchronous read port.
module lut_ram_32xw
    import lut_cfg_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [TBL_AW-1:0] waddr_i,
    input  logic [W-1:0]      wdata_i,
    input  logic [TBL_AW-1:0] raddr_i,
    output logic [W-1:0]      rdata_o
);

    logic [W-1:0] mem_q [TBL_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_ram_cfg_top.sv
// Writable 32-entry lookup table: self-initialising sweep, bulk clear, cfg write
// port and a 1-cycle registered lookup port (read-first on collisions).
module lut_ram_cfg_top
    import lut_cfg_pkg::*;
#(
    parameter int                              BUS_WIDTH  = 32,
    parameter logic [TBL_DEPTH*BUS_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [TBL_AW-1:0]    cfg_addr,
    input  logic [BUS_WIDTH-1:0] cfg_data,
    input  logic                 cfg_clr,
    output logic                 tbl_ready,
    input  logic                 rd_en,
    input  logic [TBL_AW-1:0]    rd_addr,
    output logic [BUS_WIDTH-1:0] dout,
    output logic                 rd_vld
);

    localparam logic [TBL_DEPTH*INIT_MAX_W-1:0] INIT_EXT =
        (TBL_DEPTH*INIT_MAX_W)'(INIT_VALUE);
    localparam logic [TBL_AW-1:0] LAST = TBL_AW'(TBL_DEPTH-1);

    logic [BUS_WIDTH-1:0] init_tbl [TBL_DEPTH];

    for (genvar a = 0; a < TBL_DEPTH; a++) begin : g_init
        localparam logic [INIT_MAX_W-1:0] ENT = init_entry(INIT_EXT, TBL_AW'(a));
        assign init_tbl[a] = ENT[BUS_WIDTH-1:0];
    end

    logic [1:0]           state_q, state_d;
    logic [TBL_AW-1:0]    cnt_q, cnt_d;
    logic                 ready_q;
    logic [BUS_WIDTH-1:0] dout_q;
    logic                 rd_vld_q;

    logic                 we;
    logic [TBL_AW-1:0]    waddr;
    logic [BUS_WIDTH-1:0] wdata;
    logic [BUS_WIDTH-1:0] rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = cfg_addr;
        wdata   = cfg_data;
        case (state_q)
            ST_INIT: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = init_tbl[cnt_q];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // A write paired with a clear still lands; the sweep then zeroes it.
                we = cfg_valid;
                if (cfg_clr) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    lut_ram_32xw #(.W(BUS_WIDTH)) u_ram (
        .clk     (clk),
        .we_i    (we & ~rst),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            dout_q   <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // Ready is decoded from next state so it tracks state_q with no input path.
            ready_q  <= (state_d == ST_IDLE);
            dout_q   <= rdata;
            rd_vld_q <= rd_en & ready_q;
        end
    end

    assign cfg_ready = ready_q;
    assign tbl_ready = ready_q;
    assign dout      = dout_q;
    assign rd_vld    = rd_vld_q;

endmodule

// File: tb/tb_lut_ram_cfg_top.sv
// Directed bench for lut_ram_cfg_top: init image, writes, collision, clear, reset mid-clear.
module tb_lut_ram_cfg_top;

    localparam int W = 32;

    function automatic logic [W-1:0] exp_init(input int a);
        logic [15:0] v;
        v = 16'(a);
        return {v, ~v};
    endfunction

    function automatic logic [32*W-1:0] build_img();
        logic [32*W-1:0] img;
        logic [W-1:0]    e;
        img = '0;
        for (int a = 0; a < 32; a++) begin
            e = exp_init(a);
            for (int b = 0; b < W; b++) img[32*b + a] = e[b];
        end
        return img;
    endfunction

    localparam logic [32*W-1:0] IMG = build_img();

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [4:0]   cfg_addr = '0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_clr = 1'b0;
    logic         tbl_ready;
    logic         rd_en = 1'b0;
    logic [4:0]   rd_addr = '0;
    logic [W-1:0] dout;
    logic         rd_vld;

    int ncmp = 0;
    int nfail = 0;
    int n;

    lut_ram_cfg_top #(.BUS_WIDTH(W), .INIT_VALUE(IMG)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_clr   (cfg_clr),
        .tbl_ready (tbl_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .dout      (dout),
        .rd_vld    (rd_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [W-1:0] exp);
        rd_addr = 5'(a);
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        chk($sformatf("%s_vld[%0d]", tag, a), W'(rd_vld), W'(1));
        chk($sformatf("%s_dout[%0d]", tag, a), dout, exp);
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        cfg_addr  = 5'(a);
        cfg_data  = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (cfg_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk(tag, W'(n), W'(32));
    endtask

    initial begin
        // Reset and init sweep
        repeat (3) tick();
        chk("rst_cfg_ready", W'(cfg_ready), W'(0));
        chk("rst_tbl_ready", W'(tbl_ready), W'(0));
        chk("rst_dout", dout, '0);
        chk("rst_rd_vld", W'(rd_vld), W'(0));
        rst   = 1'b0;
        rd_en = 1'b1;
        tick();
        chk("init_rd_vld", W'(rd_vld), W'(0));
        chk("init_tbl_ready", W'(tbl_ready), W'(0));
        rd_en = 1'b0;
        n = 1;
        while (cfg_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("init_len", W'(n), W'(32));
        chk("init_tbl_ready_up", W'(tbl_ready), W'(1));
        for (int a = 0; a < 32; a++) rd_chk("init", a, exp_init(a));

        // Single writes
        wr(7, 32'hDEADBEEF);
        wr(31, 32'h00000001);
        rd_chk("wr", 7, 32'hDEADBEEF);
        rd_chk("wr", 31, 32'h00000001);
        rd_chk("wr_unchanged", 8, exp_init(8));

        // Read/write collision: read-first
        rd_addr   = 5'd3;
        rd_en     = 1'b1;
        cfg_addr  = 5'd3;
        cfg_data  = 32'hA5A5A5A5;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        rd_en     = 1'b0;
        chk("coll_old", dout, exp_init(3));
        rd_chk("coll_new", 3, 32'hA5A5A5A5);

        // Back-to-back writes
        for (int a = 0; a < 32; a++) begin
            chk($sformatf("b2b_ready[%0d]", a), W'(cfg_ready), W'(1));
            cfg_addr  = 5'(a);
            cfg_data  = W'(a * 3);
            cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        for (int a = 0; a < 32; a++) rd_chk("b2b", a, W'(a * 3));

        // Clear with a simultaneous write
        cfg_clr   = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr  = 5'd5;
        cfg_data  = 32'h12345678;
        tick();
        cfg_clr   = 1'b0;
        cfg_valid = 1'b0;
        chk("clr_cfg_ready", W'(cfg_ready), W'(0));
        chk("clr_tbl_ready", W'(tbl_ready), W'(0));
        rd_en = 1'b1;
        rd_addr = 5'd5;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
            chk($sformatf("clr_rd_vld[%0d]", n), W'(rd_vld), W'(0));
        end
        rd_en = 1'b0;
        chk("clr_len", W'(n), W'(32));
        for (int a = 0; a < 32; a++) rd_chk("clr", a, '0);

        // Reset at clear cycle 10
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        repeat (10) tick();
        chk("mid_clr_busy", W'(cfg_ready), W'(0));
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", W'(cfg_ready), W'(0));
        rst = 1'b0;
        wait_ready("reinit_len");
        for (int a = 0; a < 32; a++) rd_chk("reinit", a, exp_init(a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/lut_ram_cfg_top.md
Name: lut_ram_cfg_top

Overview:
- Writable counterpart to the LUT6_2 read-only lookup ROMs.
- A 32-entry x BUS_WIDTH distributed-RAM lookup table. A control plane loads and updates it through a valid/ready write port. The parser datapath reads it through a 1-cycle registered lookup port.
- After reset, the block self-initialises from INIT_VALUE using the same column-major bit layout as the ROM images, so existing ROM init vectors load unchanged. It also supports a bulk clear command.

Parameters:
- BUS_WIDTH, 32, entry width in bits; must be even.
- INIT_VALUE, 0, 32*BUS_WIDTH-bit initial image; bit b of entry a = INIT_VALUE[32*b + a].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  write request.
- cfg_ready  out  1  write port can accept.
- cfg_addr  in  5  entry to write.
- cfg_data  in  BUS_WIDTH  write data.
- cfg_clr  in  1  single-cycle clear command, sampled only when cfg_ready=1.
- tbl_ready  out  1  table initialised and not clearing.
- rd_en  in  1  lookup request.
- rd_addr  in  5  lookup address.
- dout  out  BUS_WIDTH  registered lookup data.
- rd_vld  out  1  dout valid qualifier.

Behaviour:
- Reset values (while rst=1 at a clock edge):
  - dout=0, rd_vld=0, cfg_ready=0, tbl_ready=0.
  - state=ST_INIT, sweep counter=0.
  - Memory contents are unspecified until the INIT sweep completes.
- States: ST_INIT, ST_IDLE, ST_CLEAR.
- ST_INIT:
  - Each cycle, write INIT_VALUE entry cnt to mem[cnt], then cnt++.
  - After the write of entry 31, go to ST_IDLE and clear cnt to 0.
  - The first cycle after rst deasserts writes entry 0. ST_IDLE is entered 32 cycles after rst falls, with cfg_ready=tbl_ready=1 from that cycle onward.
- ST_IDLE:
  - cfg_ready=1.
  - cfg_valid=1 writes cfg_data to mem[cfg_addr] at that edge.
  - cfg_clr=1 moves to ST_CLEAR.
  - If cfg_valid and cfg_clr are both 1 in the same cycle, the write is performed and the clear follows. The clear overwrites it, so the net result is an all-zero table.
- ST_CLEAR:
  - Write 0 to mem[cnt] each cycle, 32 cycles.
  - cfg_ready=0 and tbl_ready=0 throughout.
  - Return to ST_IDLE after entry 31.
  - cfg_clr is ignored in this state.
- Write port handshake:
  - The transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready is a registered state decode with no combinational path from inputs.
  - While cfg_ready=0, a requester must hold cfg_addr and cfg_data stable.
- Lookup:
  - dout <= mem[rd_addr] every edge, regardless of rd_en.
  - rd_vld <= rd_en & tbl_ready.
  - Latency is 1 cycle.
  - rd_en during INIT or CLEAR returns rd_vld=0 one cycle later. The lookup is dropped, not stalled.
- Read/write collision: a lookup and a write to the same address in the same cycle returns the OLD data (read-first). The new data is visible to lookups issued from the next cycle.
- Sweep counter: 5 bits, wraps 31->0 on exit from ST_INIT or ST_CLEAR.
- Reset mid-sweep or mid-operation: the next edge with rst=1 returns to ST_INIT with cnt=0 and restarts the full 32-cycle initialisation. Pending cfg writes are not accepted.
- Storage:
  - Inferred as distributed RAM: one write port with a muxed address/data source (cfg / sweep) and one asynchronous read port, followed by the dout register.
  - No block RAM is used.

Decomposition:
- Shared package lut_cfg_pkg holds:
  - state encoding: ST_INIT, ST_IDLE, ST_CLEAR;
  - TBL_DEPTH=32 and TBL_AW=5;
  - function init_entry(img, a), which extracts entry a from a column-major image. The ROM flow also uses this function for golden-model checks.
- One sub-module: lut_ram_32xw, holding the distributed-RAM array with a synchronous write and asynchronous read. The FSM, handshake and output register stay in the top level.

Test Plan:
- Reset and initialisation:
  - Stimulus: BUS_WIDTH=32, INIT_VALUE with entry a = {a, ~a} packed column-major. Hold rst for 3 cycles, then release.
  - Required response: cfg_ready=0 for exactly 32 cycles, then 1. Lookups of all 32 addresses return entry a with rd_vld=1 one cycle later.
- Single writes:
  - Stimulus: write 0xDEADBEEF to address 7 and 0x00000001 to address 31.
  - Required response: lookups return those values; address 8 is unchanged.
- Collision:
  - Stimulus: in the same cycle, write 0xA5A5A5A5 to address 3 and look up address 3.
  - Required response: dout returns the old entry 3. A lookup the next cycle returns 0xA5A5A5A5.
- Clear with simultaneous write:
  - Stimulus: cfg_clr=1 and cfg_valid=1 to address 5 in the same cycle.
  - Required response: cfg_ready and tbl_ready are 0 for 32 cycles. A rd_en during that window gives rd_vld=0. Afterwards every address reads 0, including address 5.
- Reset mid-clear:
  - Stimulus: assert rst for 1 cycle at clear cycle 10.
  - Required response: a full 32-cycle INIT sweep follows, and the table equals INIT_VALUE again.
- Back-to-back writes:
  - Stimulus: 32 consecutive cycles of cfg_valid=1 writing data = addr*3.
  - Required response: every write is accepted in one cycle. A lookup sweep matches data = addr*3 for all 32 addresses.
